keypad_scan: RTL and testbench

// - 4x4 matrix keypad scanner: the input-side counterpart of the multiplexed 7-seg display driver.
// - Drives one column at a time (one-hot, like the digit commons) and reads the four row lines.
// - Debounces the press and reports a 4-bit key code plus a one-cycle valid strobe.
// - Its output feeds the display digit registers (num1..num4 style) or any control FSM.

---
 rtl/keypad_pkg.sv | 22 ++
 rtl/scan_tick_gen.sv | 23 ++
 rtl/keypad_scan.sv | 161 ++++++++++++++++
 tb/tb_keypad_scan.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
// The column pattern helper is shared with the multiplexed display driver.
package keypad_pkg;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } kp_state_t;

  // Active-low one-hot pattern with only column idx driven low.
  function automatic logic [COLS-1:0] col_onehot_n(input logic [1:0] idx);
    logic [COLS-1:0] pat;
    pat      = '1;
    pat[idx] = 1'b0;
    return pat;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider that emits a one-cycle enable pulse every 2**DIV_BITS clocks.
// Used as a clock-enable so every consumer stays on the single system clock.
module scan_tick_gen #(
  parameter int DIV_BITS = 14
) (
  input  logic fin,
  input  logic rst,
  output logic tick_o
);

  logic [DIV_BITS-1:0] count_q;

  always_ff @(posedge fin or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tick_o = &count_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: walks an active-low column, debounces presses and releases,
// and reports the accepted key as {row, col} with a one-cycle valid strobe.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int DIV_BITS  = 14,
  parameter int DEB_TICKS = 4
) (
  input  logic       fin,
  input  logic       rst,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int CW = $clog2(DEB_TICKS + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_TICKS - 1);

  logic            tick;
  logic [3:0]      rowsMeta_q, rowsSync_q;
  kp_state_t       state_q, state_d;
  logic [1:0]      colIdx_q, colIdx_d;
  logic [1:0]      candRow_q, candRow_d;
  logic [CW-1:0]   debCnt_q, debCnt_d;
  logic [CW-1:0]   relCnt_q, relCnt_d;
  logic [3:0]      keyCode_q, keyCode_d;
  logic            keyValid_q, keyValid_d;
  logic            keyDown_q, keyDown_d;
  logic            hit;
  logic [1:0]      hitRow;

  scan_tick_gen #(.DIV_BITS(DIV_BITS)) u_tick (
    .fin    (fin),
    .rst    (rst),
    .tick_o (tick)
  );

  // Rows come straight off the board pins, so they are synchronised before any decision.
  always_ff @(posedge fin or posedge rst) begin
    if (rst) begin
      rowsMeta_q <= 4'b1111;
      rowsSync_q <= 4'b1111;
    end else begin
      rowsMeta_q <= row_n;
      rowsSync_q <= rowsMeta_q;
    end
  end

  // Lowest low row wins when several keys share the driven column.
  always_comb begin
    hit    = ~&rowsSync_q;
    hitRow = 2'd0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (!rowsSync_q[r]) hitRow = 2'(r);
    end
  end

  always_ff @(posedge fin or posedge rst) begin
    if (rst) begin
      state_q    <= SCAN;
      colIdx_q   <= 2'd0;
      candRow_q  <= 2'd0;
      debCnt_q   <= '0;
      relCnt_q   <= '0;
      keyCode_q  <= 4'd0;
      keyValid_q <= 1'b0;
      keyDown_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      colIdx_q   <= colIdx_d;
      candRow_q  <= candRow_d;
      debCnt_q   <= debCnt_d;
      relCnt_q   <= relCnt_d;
      keyCode_q  <= keyCode_d;
      keyValid_q <= keyValid_d;
      keyDown_q  <= keyDown_d;
    end
  end

  // Counters only advance up to DEB_TICKS before the state is left, so they never wrap.
  always_comb begin
    state_d    = state_q;
    colIdx_d   = colIdx_q;
    candRow_d  = candRow_q;
    debCnt_d   = debCnt_q;
    relCnt_d   = relCnt_q;
    keyCode_d  = keyCode_q;
    keyValid_d = 1'b0;
    keyDown_d  = keyDown_q;
    case (state_q)
      SCAN: begin
        if (tick) begin
          if (hit) begin
            candRow_d = hitRow;
            if (DEB_TICKS == 1) begin
              debCnt_d   = '0;
              keyCode_d  = {hitRow, colIdx_q};
              keyValid_d = 1'b1;
              keyDown_d  = 1'b1;
              relCnt_d   = '0;
              state_d    = HOLD;
            end else begin
              debCnt_d = CW'(1);
              state_d  = DEBOUNCE;
            end
          end else begin
            colIdx_d = colIdx_q + 2'd1;
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (hit && (hitRow == candRow_q)) begin
            if (debCnt_q >= DEB_LAST) begin
              debCnt_d   = '0;
              keyCode_d  = {candRow_q, colIdx_q};
              keyValid_d = 1'b1;
              keyDown_d  = 1'b1;
              relCnt_d   = '0;
              state_d    = HOLD;
            end else begin
              debCnt_d = debCnt_q + CW'(1);
            end
          end else begin
            debCnt_d = '0;
            colIdx_d = colIdx_q + 2'd1;
            state_d  = SCAN;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          if (hit) begin
            relCnt_d = '0;
          end else if (relCnt_q >= DEB_LAST) begin
            relCnt_d  = '0;
            keyDown_d = 1'b0;
            colIdx_d  = colIdx_q + 2'd1;
            state_d   = SCAN;
          end else begin
            relCnt_d = relCnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d  = SCAN;
        colIdx_d = 2'd0;
        debCnt_d = '0;
        relCnt_d = '0;
      end
    endcase
  end

  assign col_n     = col_onehot_n(colIdx_q);
  assign key_code  = keyCode_q;
  assign key_valid = keyValid_q;
  assign key_down  = keyDown_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural 4x4 key matrix driving row_n from col_n.
// Runs with a tick every 4 clocks and 3-tick debounce.
module tb_keypad_scan;

  logic        fin;
  logic        rst;
  logic [3:0]  rowN;
  logic [3:0]  colN;
  logic [3:0]  keyCode;
  logic        keyValid;
  logic        keyDown;
  logic [15:0] pressed;
  int          testsRun;
  int          testsFailed;
  int          validPulses;

  keypad_scan #(.DIV_BITS(2), .DEB_TICKS(3)) dut (
    .fin       (fin),
    .rst       (rst),
    .row_n     (rowN),
    .col_n     (colN),
    .key_code  (keyCode),
    .key_valid (keyValid),
    .key_down  (keyDown)
  );

  initial fin = 1'b0;
  always #5 fin = ~fin;

  // A pressed key at (r,c) pulls row r low only while column c is driven low.
  always_comb begin
    rowN = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && (colN[c] == 1'b0)) rowN[r] = 1'b0;
      end
    end
  end

  always @(negedge fin) begin
    if (keyValid === 1'b1) validPulses++;
  end

  task automatic waitCol(input logic [3:0] target, output bit ok);
    int n;
    n = 0;
    while (colN == target && n < 20) begin
      @(negedge fin);
      n++;
    end
    n = 0;
    while (colN != target && n < 40) begin
      @(negedge fin);
      n++;
    end
    ok = (colN == target);
  endtask

  task automatic waitValid(input int budget, output bit found, output int n);
    found = 1'b0;
    n = 0;
    while (!found && n < budget) begin
      @(negedge fin);
      n++;
      if (keyValid === 1'b1) found = 1'b1;
    end
  endtask

  task automatic waitRelease(input int budget, output bit found);
    int n;
    found = 1'b0;
    n = 0;
    while (!found && n < budget) begin
      @(negedge fin);
      n++;
      if (keyDown === 1'b0) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge fin);
    testsRun++;
    if (colN !== 4'b1110) begin
      testsFailed++;
      $display("[TB] FAIL reset_col: got %b expected 1110", colN);
    end
    testsRun++;
    if (keyCode !== 4'b0000) begin
      testsFailed++;
      $display("[TB] FAIL reset_code: got %b expected 0000", keyCode);
    end
    testsRun++;
    if (keyValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_valid: got %b expected 0", keyValid);
    end
    testsRun++;
    if (keyDown !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_down: got %b expected 0", keyDown);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle_scan();
    logic [3:0] expCols [5];
    int start;
    expCols = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    start = validPulses;
    repeat (2) @(negedge fin);
    for (int i = 0; i < 5; i++) begin
      testsRun++;
      if (colN !== expCols[i]) begin
        testsFailed++;
        $display("[TB] FAIL idle_col%0d: got %b expected %b", i, colN, expCols[i]);
      end
      repeat (4) @(negedge fin);
    end
    testsRun++;
    if (validPulses != start) begin
      testsFailed++;
      $display("[TB] FAIL idle_pulses: got %0d expected 0", validPulses - start);
    end
  endtask

  task automatic test_press_release();
    bit ok;
    bit found;
    int n;
    int start;
    waitCol(4'b1101, ok);
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL press_reach_col1: got %b expected 1101", colN);
    end
    start = validPulses;
    pressed[2*4+1] = 1'b1;
    waitValid(40, found, n);
    testsRun++;
    if (!found || n != 12) begin
      testsFailed++;
      $display("[TB] FAIL press_latency: got %0d cycles (found=%0b) expected 12", n, found);
    end
    testsRun++;
    if (keyCode !== 4'b1001) begin
      testsFailed++;
      $display("[TB] FAIL press_code: got %b expected 1001", keyCode);
    end
    testsRun++;
    if (keyDown !== 1'b1 || colN !== 4'b1101) begin
      testsFailed++;
      $display("[TB] FAIL press_hold: got down=%b col=%b expected down=1 col=1101", keyDown, colN);
    end
    repeat (8) @(negedge fin);
    testsRun++;
    if (validPulses != start + 1) begin
      testsFailed++;
      $display("[TB] FAIL press_pulses: got %0d expected 1", validPulses - start);
    end
    pressed = '0;
    repeat (4) @(negedge fin);
    testsRun++;
    if (keyDown !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL release_early: got down=%b expected 1", keyDown);
    end
    waitRelease(40, found);
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL release_timeout: got down=%b expected 0", keyDown);
    end
    testsRun++;
    if (colN !== 4'b1011 || keyCode !== 4'b1001) begin
      testsFailed++;
      $display("[TB] FAIL release_resume: got col=%b code=%b expected col=1011 code=1001", colN, keyCode);
    end
  endtask

  task automatic test_bounce();
    bit ok;
    int start;
    waitCol(4'b1011, ok);
    testsRun++;
    if (!ok) begin
      testsFailed++;
      $display("[TB] FAIL bounce_reach_col2: got %b expected 1011", colN);
    end
    start = validPulses;
    pressed[1*4+2] = 1'b1;
    repeat (4) @(negedge fin);
    pressed = '0;
    repeat (3) @(negedge fin);
    testsRun++;
    if (colN !== 4'b1011) begin
      testsFailed++;
      $display("[TB] FAIL bounce_held: got %b expected 1011", colN);
    end
    @(negedge fin);
    testsRun++;
    if (colN !== 4'b0111) begin
      testsFailed++;
      $display("[TB] FAIL bounce_next_col: got %b expected 0111", colN);
    end
    repeat (8) @(negedge fin);
    testsRun++;
    if (validPulses != start || keyDown !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL bounce_no_key: got pulses=%0d down=%b expected 0 and 0", validPulses - start, keyDown);
    end
  endtask

  task automatic test_priority();
    bit found;
    int n;
    pressed[1*4+3] = 1'b1;
    pressed[3*4+3] = 1'b1;
    waitValid(80, found, n);
    testsRun++;
    if (!found || keyCode !== 4'b0111) begin
      testsFailed++;
      $display("[TB] FAIL priority_code: got %b (found=%0b) expected 0111", keyCode, found);
    end
    pressed = '0;
    waitRelease(60, found);
    testsRun++;
    if (!found) begin
      testsFailed++;
      $display("[TB] FAIL priority_release: got down=%b expected 0", keyDown);
    end
  endtask

  task automatic test_back_to_back();
    bit found;
    int n;
    int start;
    start = validPulses;
    pressed[2*4+1] = 1'b1;
    waitValid(80, found, n);
    testsRun++;
    if (!found || keyCode !== 4'b1001) begin
      testsFailed++;
      $display("[TB] FAIL b2b_first: got %b (found=%0b) expected 1001", keyCode, found);
    end
    pressed[0*4+3] = 1'b1;
    repeat (30) @(negedge fin);
    testsRun++;
    if (validPulses != start + 1 || keyCode !== 4'b1001 || keyDown !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL b2b_ignored: got pulses=%0d code=%b down=%b expected 1 1001 1", validPulses - start, keyCode, keyDown);
    end
    pressed[2*4+1] = 1'b0;
    waitValid(80, found, n);
    testsRun++;
    if (!found || keyCode !== 4'b0011) begin
      testsFailed++;
      $display("[TB] FAIL b2b_second: got %b (found=%0b) expected 0011", keyCode, found);
    end
    repeat (4) @(negedge fin);
    testsRun++;
    if (validPulses != start + 2 || keyDown !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL b2b_count: got pulses=%0d down=%b expected 2 1", validPulses - start, keyDown);
    end
    pressed = '0;
    waitRelease(60, found);
    pressed[0*4+3] = 1'b1;
    waitValid(80, found, n);
    repeat (4) @(negedge fin);
    testsRun++;
    if (!found || keyCode !== 4'b0011 || validPulses != start + 3) begin
      testsFailed++;
      $display("[TB] FAIL b2b_repress: got code=%b pulses=%0d expected 0011 3", keyCode, validPulses - start);
    end
    pressed = '0;
    waitRelease(60, found);
  endtask

  task automatic test_reset_mid();
    bit found;
    int n;
    pressed[2*4+1] = 1'b1;
    waitValid(80, found, n);
    @(negedge fin);
    rst = 1'b1;
    #1;
    testsRun++;
    if (colN !== 4'b1110 || keyCode !== 4'b0000 || keyDown !== 1'b0 || keyValid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid: got col=%b code=%b down=%b valid=%b expected 1110 0000 0 0", colN, keyCode, keyDown, keyValid);
    end
    pressed = '0;
    @(negedge fin);
    rst = 1'b0;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    validPulses = 0;
    pressed     = '0;
    rst         = 1'b1;
    test_reset();
    test_idle_scan();
    test_press_release();
    test_bounce();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
